// File: rtl/sync_debounce.sv
// sync_debounce: per-channel multi-flop synchronizer followed by a
// counter-based debouncer, with registered rise/fall edge pulses.
// There is no handshake in this block: in is sampled every clock, and
// out/rise/fall are plain registered levels/pulses valid every cycle.
module sync_debounce #(
  parameter int              WIDTH     = 4,
  parameter int              STAGES    = 2,
  parameter int              DB_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] load;

  // Synchronizer chain: straight flop-to-flop, no logic between stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[STAGES-1];

  // A channel updates when it has disagreed with out on DB_CYCLES edges in a row.
  always_comb begin
    diff = sync ^ out;
    load = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load[i] = diff[i] && (cnt[i] == CNT_MAX);
    end
  end

  // Debounce counters, debounced level and edge pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!diff[i] || load[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      out  <= out ^ load;
      rise <= load & sync;
      fall <= load & ~sync;
    end
  end

endmodule
